mem_arbiter_ctrl: RTL and testbench
===================================

# mem_arbiter_ctrl

Two-requester memory arbiter sitting between the instruction cache, the data cache and the single RAM port. It drives the RAM side and presents per-cache wait/load handshakes. It grants one transaction at a time, gives the data cache priority, and bounds instruction-fetch starvation with a counter. It reissues transactions that the RAM reports as ERROR.

## Interface
- STARVE_LIMIT, 4: consecutive D grants allowed while iREN pending before I is forced (1..15)
- ERRW, 8: width of saturating error counter

- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address (word_t)
- iwait  out  1  icache stall; low for exactly the completing cycle
- iload  out  32  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; low for exactly the completing cycle
- dload  out  32  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR
- err_count  out  ERRW  saturating count of ERROR responses

## Operation
- Registered state: IDLE, GRANT, RETRY; owner reg (I/D); starve counter (4 bits); err_count.
- IDLE: enables low, both waits high.
  - If dREN|dWEN and not (iREN && starve==STARVE_LIMIT), then owner=D, starve+=1 if iREN else starve=0, go GRANT.
  - Else if iREN, then owner=I, starve=0, go GRANT.
  - Else stay in IDLE.
- GRANT: RAM outputs are combinational from the owner's live inputs.
  - Owner I: ramREN=iREN, ramaddr=iaddr, ramWEN=0.
  - Owner D: ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both set), ramaddr=daddr, ramstore=dstore.
  - ramstate==ACCESS: owner wait=0 this cycle. Owner load=ramload on reads, else 0. Next state IDLE.
  - ramstate==ERROR: err_count+=1 (saturate at all-ones), go RETRY.
  - ramstate FREE/BUSY: hold.
  - Owner drops all its enables before ACCESS: abort; enables follow inputs (low), return to IDLE, no completion.
- RETRY: enables low, waits high for one cycle, then GRANT with the same owner.
- Non-owner wait is always high. iload/dload are 0 except on the owner's completing read cycle.
- Requesters hold address/data stable while wait is high.

## Timing
- Reset (nRST low, asynchronous): state=IDLE, owner=D, starve=0, err_count=0. Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
- Reset mid-transaction drops the RAM enables immediately. The transaction is lost; requesters re-request.
- Request seen in IDLE at cycle N: enables asserted at cycle N+1. Earliest completion (wait low) is N+1 if RAM returns ACCESS that cycle, so minimum latency is 2 cycles from request.
- After completion, one IDLE cycle always separates transactions (back-to-back: completions no closer than every 2 cycles).
- Simultaneous I and D requests in IDLE: D wins unless starve==STARVE_LIMIT.
- ERROR adds 2 cycles (RETRY plus re-GRANT) before ACCESS can be taken again.
- Combinational paths: inputs to RAM outputs, and ramstate/ramload to wait/load. No combinational path from ram* inputs back to ram* outputs.

## Test plan
- Reset check: hold nRST low → iwait=dwait=1, ramREN=ramWEN=0, err_count=0. Release with no requests → all outputs unchanged.
- Single I read: iREN=1, iaddr=0x100. RAM returns ACCESS on the 2nd grant cycle with ramload=0xDEADBEEF → ramaddr=0x100, ramREN=1, iwait low for exactly 1 cycle with iload=0xDEADBEEF, then IDLE.
- Simultaneous: iREN and dWEN asserted same cycle, daddr=0x200, dstore=0x5 → D granted first (ramWEN=1, ramstore=0x5). I is granted in the next arbitration.
- Starvation: iREN held while dREN is continuously re-requested, RAM ACCESS immediate, STARVE_LIMIT=4 → exactly 4 D completions, then 1 I completion, then D again.
- Error retry: dREN, ramstate=ERROR once then ACCESS → err_count=1. ramREN low for one RETRY cycle, then reissued to the same daddr. dwait low once.
- Abort/reset: owner drops dREN during BUSY → IDLE next cycle, dwait never low. Separately, nRST pulsed during GRANT → ramREN falls the same cycle.

Source files
------------

// File: rtl/mem_arbiter_ctrl.sv
// Two-requester RAM arbiter: dcache priority, bounded icache starvation, ERROR retry.
// Ports: CLK/nRST, icache (iREN/iaddr/iwait/iload), dcache (dREN/dWEN/daddr/dstore/dwait/dload),
//        RAM side (ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate), err_count.

package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module mem_arbiter_ctrl
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ERRW         = 8
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            iREN,
    input  logic [31:0]     iaddr,
    output logic            iwait,
    output logic [31:0]     iload,
    input  logic            dREN,
    input  logic            dWEN,
    input  logic [31:0]     daddr,
    input  logic [31:0]     dstore,
    output logic            dwait,
    output logic [31:0]     dload,
    output logic            ramREN,
    output logic            ramWEN,
    output logic [31:0]     ramaddr,
    output logic [31:0]     ramstore,
    input  logic [31:0]     ramload,
    input  ramstate_t       ramstate,
    output logic [ERRW-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RETRY = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic [3:0]      starve_q, starve_d;
    logic [ERRW-1:0] err_q, err_d;

    logic d_req;
    logic own_act;
    logic own_rd;

    assign err_count = err_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        err_d    = err_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        d_req    = dREN | dWEN;
        own_act  = 1'b0;
        own_rd   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // D wins unless I has already waited out STARVE_LIMIT D grants
                if (d_req && !(iREN && starve_q == LIM)) begin
                    owner_d  = OWN_D;
                    starve_d = iREN ? starve_q + 4'd1 : 4'd0;
                    state_d  = GRANT;
                end else if (iREN) begin
                    owner_d  = OWN_I;
                    starve_d = 4'd0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (owner_q == OWN_I) begin
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    own_act = iREN;
                    own_rd  = iREN;
                end else begin
                    // write wins when both enables are set
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    own_act  = d_req;
                    own_rd   = dREN & ~dWEN;
                end
                if (!own_act) begin
                    // owner withdrew before completion: abort quietly
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    if (owner_q == OWN_I) begin
                        iwait = 1'b0;
                        iload = own_rd ? ramload : '0;
                    end else begin
                        dwait = 1'b0;
                        dload = own_rd ? ramload : '0;
                    end
                end else if (ramstate == ERROR) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERRW'(1);
                    end
                    state_d = RETRY;
                end
            end
            RETRY: begin
                state_d = GRANT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            owner_q  <= OWN_D;
            starve_q <= 4'd0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: reset, single read, priority,
// starvation bound, ERROR retry, abort and mid-grant reset.
module tb_mem_arbiter_ctrl;
    import mem_arbiter_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    logic [7:0]  err_count;

    int checks;
    int errors;

    mem_arbiter_ctrl #(.STARVE_LIMIT(4), .ERRW(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err_count(err_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        #3;
        checks++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctl got %b want 1100", {iwait, dwait, ramREN, ramWEN});
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_err got %0d want 0", err_count);
        end
        checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {ramaddr, ramstore, iload, dload});
        end
        tick(); tick();
        nRST = 1'b1;
        tick(); tick();
        checks++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_idle got %b/%0d want 1100/0",
                     {iwait, dwait, ramREN, ramWEN}, err_count);
        end
    endtask

    task automatic test_i_read();
        iREN = 1; iaddr = 32'h100; ramstate = FREE;
        #1;
        checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL iread_idle got ren=%b iwait=%b want 0/1", ramREN, iwait);
        end
        tick();
        ramstate = BUSY;
        #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h100 || iwait !== 1'b1 || ramWEN !== 1'b0) begin
            errors++;
            $display("FAIL iread_grant1 got ren=%b addr=%h iwait=%b wen=%b want 1/100/1/0",
                     ramREN, ramaddr, iwait, ramWEN);
        end
        tick();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        checks++;
        if (iwait !== 1'b0 || iload !== 32'hDEADBEEF || dwait !== 1'b1) begin
            errors++;
            $display("FAIL iread_done got iwait=%b iload=%h dwait=%b want 0/deadbeef/1",
                     iwait, iload, dwait);
        end
        tick();
        iREN = 0; ramstate = FREE;
        #1;
        checks++;
        if (iwait !== 1'b1 || iload !== 32'd0 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL iread_after got iwait=%b iload=%h ren=%b want 1/0/0",
                     iwait, iload, ramREN);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        iREN = 1; iaddr = 32'h300;
        dWEN = 1; daddr = 32'h200; dstore = 32'h5; ramstate = FREE;
        tick();
        ramstate = ACCESS; ramload = 32'h1234;
        #1;
        checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'h5) begin
            errors++;
            $display("FAIL simul_dgrant got wen=%b ren=%b addr=%h st=%h want 1/0/200/5",
                     ramWEN, ramREN, ramaddr, ramstore);
        end
        checks++;
        if (dwait !== 1'b0 || dload !== 32'd0 || iwait !== 1'b1 || iload !== 32'd0) begin
            errors++;
            $display("FAIL simul_dwrite_done got dwait=%b dload=%h iwait=%b want 0/0/1",
                     dwait, dload, iwait);
        end
        tick();
        dWEN = 0; ramstate = FREE;
        #1;
        checks++;
        if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL simul_gap got wen=%b ren=%b want 0/0", ramWEN, ramREN);
        end
        tick();
        ramstate = ACCESS;
        #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h300 || iwait !== 1'b0 || iload !== 32'h1234) begin
            errors++;
            $display("FAIL simul_igrant got ren=%b addr=%h iwait=%b iload=%h want 1/300/0/1234",
                     ramREN, ramaddr, iwait, iload);
        end
        tick();
        iREN = 0; ramstate = FREE;
        tick();
    endtask

    task automatic test_starvation();
        // per cycle: 0 none, 1 D completes, 2 I completes
        int exp_c [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 2, 0, 1};
        logic [1:0] ew;
        iREN = 1; iaddr = 32'h500;
        dREN = 1; daddr = 32'h600;
        ramstate = ACCESS; ramload = 32'hA5A5;
        for (int c = 0; c < 12; c++) begin
            #1;
            ew = (exp_c[c] == 1) ? 2'b10 : (exp_c[c] == 2) ? 2'b01 : 2'b11;
            checks++;
            if ({iwait, dwait} !== ew) begin
                errors++;
                $display("FAIL starve_c%0d got iwait,dwait=%b want %b", c, {iwait, dwait}, ew);
            end
            if (exp_c[c] != 0) begin
                checks++;
                if ((exp_c[c] == 1 ? dload : iload) !== 32'hA5A5) begin
                    errors++;
                    $display("FAIL starve_load_c%0d got i=%h d=%h want a5a5", c, iload, dload);
                end
            end
            tick();
        end
        iREN = 0; dREN = 0; ramstate = FREE;
        tick();
    endtask

    task automatic test_error_retry();
        dREN = 1; daddr = 32'h40; ramstate = FREE;
        tick();
        ramstate = ERROR;
        #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL err_grant got ren=%b addr=%h dwait=%b want 1/40/1", ramREN, ramaddr, dwait);
        end
        tick();
        ramstate = FREE;
        #1;
        checks++;
        if (ramREN !== 1'b0 || dwait !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL err_retry got ren=%b dwait=%b err=%0d want 0/1/1", ramREN, dwait, err_count);
        end
        tick();
        ramstate = ACCESS; ramload = 32'h77;
        #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || dwait !== 1'b0 || dload !== 32'h77) begin
            errors++;
            $display("FAIL err_reissue got ren=%b addr=%h dwait=%b dload=%h want 1/40/0/77",
                     ramREN, ramaddr, dwait, dload);
        end
        tick();
        dREN = 0; ramstate = FREE;
        #1;
        checks++;
        if (dwait !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL err_after got dwait=%b err=%0d want 1/1", dwait, err_count);
        end
        tick();
    endtask

    task automatic test_abort_reset();
        dREN = 1; daddr = 32'h80; ramstate = BUSY;
        tick();
        #1;
        checks++;
        if (ramREN !== 1'b1 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_grant got ren=%b dwait=%b want 1/1", ramREN, dwait);
        end
        tick();
        dREN = 0;
        #1;
        checks++;
        if (ramREN !== 1'b0 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_drop got ren=%b dwait=%b want 0/1", ramREN, dwait);
        end
        tick();
        dREN = 1;
        #1;
        checks++;
        if (ramREN !== 1'b0 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle got ren=%b dwait=%b want 0/1", ramREN, dwait);
        end
        tick();
        #1;
        checks++;
        if (ramREN !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got ren=%b want 1", ramREN);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (ramREN !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid got ren=%b dwait=%b addr=%h want 0/1/0", ramREN, dwait, ramaddr);
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_err got %0d want 0", err_count);
        end
        dREN = 0; ramstate = FREE;
        #1;
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_i_read();
        test_simultaneous();
        test_starvation();
        test_error_retry();
        test_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
